// File: rtl/fv_enc_pkg.sv
// Shared types and sizing helpers for the fv_enc stream sink.
package fv_enc_pkg;

   localparam int FIFO_DEPTH = 4;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } fsm_e;

   function automatic int lenw(input int n);
      return $clog2(n) + 2;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Writes into a full FIFO and reads from an empty one are ignored.
module sync_fifo
   import fv_enc_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          s_rst_n,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_wr;
   logic          do_rd;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rptr];

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_wr) wptr <= inc(wptr);
         if (do_rd) rptr <= inc(rptr);
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

endmodule

// File: rtl/frame_check_sink.sv
// Frame sink: buffers beats, accumulates XOR/sum/length per frame and
// hands each frame result out over a valid/ready result port.
module frame_check_sink
   import fv_enc_pkg::*;
#(
   parameter int N     = 16,
   parameter int DATAW = 64
) (
   input  logic                 clk,
   input  logic                 s_rst_n,
   input  logic                 s_valid,
   input  logic                 s_last,
   input  logic [DATAW-1:0]     s_data,
   output logic                 s_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [DATAW-1:0]     res_xor,
   output logic [DATAW-1:0]     res_sum,
   output logic [lenw(N)-1:0]   res_len,
   output logic                 res_err,
   output logic                 ovf
);

   localparam int LENW = lenw(N);
   localparam int CW   = $clog2(FIFO_DEPTH + 1);
   localparam logic [LENW-1:0] LEN_MAX = '1;

   fsm_e             state;
   fsm_e             state_nx;
   logic             pop;
   logic             full;
   logic             empty;
   logic [CW-1:0]    count;
   logic [DATAW:0]   rd_word;
   logic             rd_last;
   logic [DATAW-1:0] rd_data;

   logic [DATAW-1:0] acc_xor;
   logic [DATAW-1:0] acc_sum;
   logic [LENW-1:0]  acc_len;
   logic [DATAW-1:0] nx_xor;
   logic [DATAW-1:0] nx_sum;
   logic [LENW-1:0]  nx_len;

   sync_fifo #(
      .W     (DATAW + 1),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .s_rst_n (s_rst_n),
      .wr_en   (s_valid),
      .wr_data ({s_last, s_data}),
      .rd_en   (pop),
      .rd_data (rd_word),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign rd_last   = rd_word[DATAW];
   assign rd_data   = rd_word[DATAW-1:0];
   assign s_ready   = (count <= CW'(FIFO_DEPTH - 2));
   assign res_valid = (state == DONE);

   assign nx_xor = acc_xor ^ rd_data;
   assign nx_sum = acc_sum + rd_data;
   assign nx_len = (acc_len == LEN_MAX) ? LEN_MAX
                                        : acc_len + LENW'(1);

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      unique case (state)
         ACCUM: begin
            if (!empty) begin
               pop = 1'b1;
               if (rd_last) state_nx = DONE;
            end
         end
         DONE: begin
            if (res_ready) state_nx = ACCUM;
         end
         default: state_nx = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state   <= ACCUM;
         acc_xor <= '0;
         acc_sum <= '0;
         acc_len <= '0;
         res_xor <= '0;
         res_sum <= '0;
         res_len <= '0;
         res_err <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         state <= state_nx;
         // full is the registered flag, so a write that coincides with a
         // pop from a full FIFO is still dropped and flagged
         if (s_valid && full) ovf <= 1'b1;
         if (pop) begin
            if (rd_last) begin
               res_xor <= nx_xor;
               res_sum <= nx_sum;
               res_len <= nx_len;
               res_err <= (nx_len != LENW'(N));
               acc_xor <= '0;
               acc_sum <= '0;
               acc_len <= '0;
            end else begin
               acc_xor <= nx_xor;
               acc_sum <= nx_sum;
               acc_len <= nx_len;
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_check_sink.sv
// Directed bench for frame_check_sink with a frame-level scoreboard.
module tb_frame_check_sink;

   localparam int N     = 4;
   localparam int DATAW = 8;
   localparam int LENW  = 4;

   typedef struct {
      logic [DATAW-1:0] x;
      logic [DATAW-1:0] s;
      logic [LENW-1:0]  len;
      logic             err;
   } res_t;

   logic             clk = 1'b0;
   logic             s_rst_n = 1'b0;
   logic             s_valid = 1'b0;
   logic             s_last = 1'b0;
   logic [DATAW-1:0] s_data = '0;
   logic             s_ready;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic [DATAW-1:0] res_xor;
   logic [DATAW-1:0] res_sum;
   logic [LENW-1:0]  res_len;
   logic             res_err;
   logic             ovf;

   int   n_checks = 0;
   int   n_fail = 0;
   int   n_res = 0;
   logic cr = 1'b1;
   res_t exp_q[$];

   frame_check_sink #(.N(N), .DATAW(DATAW)) dut (
      .clk       (clk),
      .s_rst_n   (s_rst_n),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_xor   (res_xor),
      .res_sum   (res_sum),
      .res_len   (res_len),
      .res_err   (res_err),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Frame-level model: what the result must be for a given beat list
   function automatic res_t model(input logic [DATAW-1:0] b[$]);
      res_t r;
      int   n;
      r.x = '0;
      r.s = '0;
      n = b.size();
      foreach (b[i]) begin
         r.x = r.x ^ b[i];
         r.s = r.s + b[i];
      end
      r.len = (n > 15) ? 4'd15 : LENW'(n);
      r.err = (n != N);
      return r;
   endfunction

   always @(negedge clk) cr <= s_ready;

   // Compare process: every accepted result against the scoreboard
   always @(negedge clk) begin
      if (s_rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
         n_res++;
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            check("sb_xor", res_xor, e.x);
            check("sb_sum", res_sum, e.s);
            check("sb_len", res_len, e.len);
            check("sb_err", res_err, e.err);
         end
      end
   end

   task automatic beat(input logic [DATAW-1:0] d, input logic l);
      int w;
      w = 0;
      while (!cr && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (!cr) check("credit_timeout", 1, 0);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [DATAW-1:0] b[$]);
      exp_q.push_back(model(b));
      foreach (b[i]) beat(b[i], i == b.size() - 1);
   endtask

   task automatic do_reset();
      s_rst_n = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      s_rst_n = 1'b1;
   endtask

   task automatic wait_valid(input string name);
      int w;
      w = 0;
      while (res_valid !== 1'b1 && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (res_valid !== 1'b1) check(name, 0, 1);
   endtask

   task automatic drain(input string name);
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 300) begin
         @(posedge clk);
         #1;
         w++;
      end
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      logic [DATAW-1:0] fr[$];
      logic             saw_low;
      logic             ovf_seen;
      int               r0;

      repeat (3) @(posedge clk);
      #1;
      s_rst_n = 1'b1;
      @(negedge clk);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_xor", res_xor, 0);
      check("rst_res_sum", res_sum, 0);
      check("rst_res_len", res_len, 0);
      check("rst_res_err", res_err, 0);
      check("rst_ovf", ovf, 0);
      check("rst_s_ready", s_ready, 1);
      @(posedge clk);
      #1;

      // Nominal frame and two-cycle latency
      fr = '{8'd1, 8'd2, 8'd3, 8'd4};
      send_frame(fr);
      check("lat_t1_valid", res_valid, 0);
      @(posedge clk);
      #1;
      check("lat_t2_valid", res_valid, 1);
      check("nom_xor", res_xor, 8'd4);
      check("nom_sum", res_sum, 8'd10);
      check("nom_len", res_len, 4'd4);
      check("nom_err", res_err, 0);
      repeat (3) @(posedge clk);
      #1;

      // Short frame
      fr = '{8'd5, 8'd3};
      send_frame(fr);
      @(posedge clk);
      #1;
      check("short_valid", res_valid, 1);
      check("short_xor", res_xor, 8'd6);
      check("short_sum", res_sum, 8'd8);
      check("short_len", res_len, 4'd2);
      check("short_err", res_err, 1);
      repeat (3) @(posedge clk);
      #1;

      // Sum wrap, also shows accumulators were cleared
      fr = '{8'hFF, 8'h02, 8'h10, 8'h01};
      send_frame(fr);
      @(posedge clk);
      #1;
      check("wrap_sum", res_sum, 8'h12);
      check("wrap_xor", res_xor, 8'hEC);
      check("wrap_err", res_err, 0);
      repeat (3) @(posedge clk);
      #1;

      // Long frame, length saturates
      fr.delete();
      for (int i = 1; i <= 18; i++) fr.push_back(DATAW'(i));
      send_frame(fr);
      @(posedge clk);
      #1;
      check("long_len", res_len, 4'd15);
      check("long_err", res_err, 1);
      check("long_sum", res_sum, 8'd171);
      drain("drain_directed");

      // Backpressure with a credit-compliant streaming upstream
      res_ready = 1'b0;
      saw_low   = 1'b0;
      ovf_seen  = 1'b0;
      fork
         begin
            for (int f = 0; f < 5; f++) begin
               logic [DATAW-1:0] b[$];
               b.delete();
               for (int i = 0; i < N; i++) b.push_back(DATAW'(f * 16 + i * 3 + 1));
               send_frame(b);
            end
         end
         begin
            repeat (30) begin
               @(negedge clk);
               if (!s_ready) saw_low = 1'b1;
               if (ovf) ovf_seen = 1'b1;
            end
            @(posedge clk);
            #1;
            res_ready = 1'b1;
         end
      join
      drain("drain_backpressure");
      check("bp_s_ready_fell", saw_low, 1);
      check("bp_ovf_clear", ovf_seen | ovf, 0);

      // Overflow with result port stalled
      res_ready = 1'b0;
      fr = '{8'd7};
      send_frame(fr);
      wait_valid("ovf_wait_valid");
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_last  = 1'b0;
         s_data  = DATAW'(i + 8'h20);
         @(posedge clk);
         #1;
         if (i == 3) check("ovf_after_4", ovf, 0);
      end
      s_valid = 1'b0;
      check("ovf_after_5", ovf, 1);
      res_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("ovf_sticky", ovf, 1);
      check("ovf_frame_drained", exp_q.size(), 0);
      do_reset();
      @(negedge clk);
      check("ovf_cleared_by_reset", ovf, 0);
      check("reset_s_ready", s_ready, 1);
      @(posedge clk);
      #1;

      // Reset mid-frame
      beat(8'd9, 1'b0);
      beat(8'd9, 1'b0);
      @(posedge clk);
      #2;
      do_reset();
      r0 = n_res;
      fr = '{8'd1, 8'd2, 8'd3, 8'd4};
      send_frame(fr);
      repeat (10) @(posedge clk);
      #1;
      check("midrst_one_result", n_res - r0, 1);
      check("midrst_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
